// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: glyphs,
// converter FSM states and small sizing/lookup helpers.
package seg_pkg;

  typedef enum logic {ST_IDLE, ST_CONV} conv_state_t;

  // Glyphs are active-high, bit 6 = a ... bit 0 = g; polarity is applied at the pins
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Scan index width; a single digit still gets a 1-bit index
  function automatic int idxWidth(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  function automatic logic [6:0] hexGlyph(input logic [3:0] v);
    case (v)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      4'hF: return SEG_F;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_mux_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, DATA_W cycles per
// conversion; result and overflow are presented combinationally on the done cycle.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_t        r_state;
  conv_state_t        w_nextState;
  logic [DATA_W-1:0]  r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_count;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_shiftBcd;
  logic               w_carry;

  // Add-3 correction on every nibble, then shift; the bit leaving the top nibble is overflow
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_shiftBcd = {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
    w_carry    = w_adj[BCD_W-1];
  end

  always_comb begin
    w_nextState = r_state;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_nextState = ST_CONV;
      ST_CONV: begin
        if (r_count == CNT_W'(DATA_W - 1)) begin
          done        = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign busy     = (r_state == ST_CONV);
  assign bcd_out  = w_shiftBcd;
  assign overflow = r_ovf | w_carry;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_bin   <= bin_in;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (r_state == ST_CONV) begin
      r_bin   <= r_bin << 1;
      r_bcd   <= w_shiftBcd;
      r_ovf   <= r_ovf | w_carry;
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: hex or decimal rendering into a shadow
// register, leading-zero blanking, overflow dashes and a registered scan stage.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] display_number,
  input  logic              load,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic [DIGITS-1:0] anode_activate,
  output logic [6:0]        led_out,
  output logic              dp_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = idxWidth(DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int PAD_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        LED_OFF   = {7{ACTIVE_LOW}};

  logic              w_convBusy, w_convDone, w_convOvf;
  logic [BCD_W-1:0]  w_convBcd;
  logic              w_accept, w_hexLoad, w_decStart, w_hexOvf;
  logic [PAD_W-1:0]  w_numPad;
  logic [BCD_W-1:0]  r_shadow;
  logic              r_ovf, r_blankLz;
  logic [PRE_W-1:0]  r_prescale;
  logic [IDX_W-1:0]  r_scanIdx;
  logic [DIGITS-1:0] r_anode;
  logic [6:0]        r_led;
  logic              r_dp;
  logic [3:0]        w_digit;
  logic              w_dpBit, w_seen;
  logic [DIGITS-1:0] w_visible, w_anodeOn;
  logic [6:0]        w_glyph;

  assign w_accept   = load && !w_convBusy;
  assign w_hexLoad  = w_accept && !mode;
  assign w_decStart = w_accept && mode;
  assign w_numPad   = PAD_W'(display_number);

  // Any set bit beyond the displayable nibbles means the hex value does not fit
  always_comb begin
    w_hexOvf = 1'b0;
    for (int b = BCD_W; b < PAD_W; b++) w_hexOvf = w_hexOvf | w_numPad[b];
  end

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .start    (w_decStart),
    .bin_in   (display_number),
    .busy     (w_convBusy),
    .done     (w_convDone),
    .bcd_out  (w_convBcd),
    .overflow (w_convOvf)
  );

  assign busy = w_convBusy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow  <= '0;
      r_ovf     <= 1'b0;
      r_blankLz <= 1'b0;
    end else begin
      if (w_accept) r_blankLz <= blank_lz;
      if (w_hexLoad) begin
        r_shadow <= w_numPad[BCD_W-1:0];
        r_ovf    <= w_hexOvf;
      end else if (w_convDone) begin
        r_shadow <= w_convBcd;
        r_ovf    <= w_convOvf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prescale <= '0;
      r_scanIdx  <= '0;
    end else if (r_prescale == PRE_W'(REFRESH_DIV - 1)) begin
      r_prescale <= '0;
      r_scanIdx  <= (r_scanIdx == IDX_W'(DIGITS - 1)) ? '0 : r_scanIdx + 1'b1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // A digit is lit if it or any more-significant digit is non-zero; digit 0 always lit
  always_comb begin
    w_seen    = 1'b0;
    w_visible = '0;
    w_digit   = 4'd0;
    w_dpBit   = 1'b0;
    w_anodeOn = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_seen       = w_seen | (r_shadow[4*i +: 4] != 4'd0);
      w_visible[i] = w_seen || (i == 0) || !r_blankLz || r_ovf;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scanIdx == IDX_W'(i)) begin
        w_digit      = r_shadow[4*i +: 4];
        w_dpBit      = dp_mask[i];
        w_anodeOn[i] = w_visible[i];
      end
    end
    w_glyph = r_ovf ? SEG_DASH : hexGlyph(w_digit);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_anode <= ANODE_OFF;
      r_led   <= LED_OFF;
      r_dp    <= ACTIVE_LOW;
    end else begin
      r_anode <= w_anodeOn ^ ANODE_OFF;
      r_led   <= w_glyph ^ LED_OFF;
      r_dp    <= w_dpBit ^ ACTIVE_LOW;
    end
  end

  assign anode_activate = r_anode;
  assign led_out        = r_led;
  assign dp_out         = r_dp;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed vector bench for seg_display_mux (4 digits, 4-cycle slots, active-low pins).
module tb_seg_display_mux;

  localparam logic [6:0] G_0 = 7'b1111110, G_1 = 7'b0110000, G_2 = 7'b1101101;
  localparam logic [6:0] G_3 = 7'b1111001, G_4 = 7'b0110011, G_5 = 7'b1011011;
  localparam logic [6:0] G_7 = 7'b1110000, G_9 = 7'b1111011, G_A = 7'b1110111;
  localparam logic [6:0] G_B = 7'b0011111, G_C = 7'b1001110, G_D = 7'b0111101;
  localparam logic [6:0] G_E = 7'b1001111, G_F = 7'b1000111, G_DASH = 7'b0000001;

  typedef struct {
    logic            mode;
    logic            blank;
    logic [15:0]     num;
    logic [3:0]      dp;
    logic [3:0][6:0] glyph;
    logic [3:0]      vis;
    int              busyLen;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] display_number = '0;
  logic        load = 1'b0, mode = 1'b0, blank_lz = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        busy;
  logic [3:0]  anode_activate;
  logic [6:0]  led_out;
  logic        dp_out;

  int vecCount = 0;
  int missCount = 0;
  int cyc = 0;
  vec_t vecs[11];

  seg_display_mux #(.DIGITS(4), .DATA_W(16), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .display_number(display_number), .load(load),
    .mode(mode), .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy),
    .anode_activate(anode_activate), .led_out(led_out), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  // Running-edge count since reset release gives the expected scan slot
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic b, input logic [15:0] num,
                               input logic [3:0] dp);
    mode = m; blank_lz = b; display_number = num; dp_mask = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic waitBusy(input string name, input int expLen);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    compare({name, " busy cycles"}, 32'(n), 32'(expLen));
  endtask

  task automatic checkOutput(input string name, input logic [3:0][6:0] glyph,
                             input logic [3:0] vis, input logic [3:0] dp);
    int slot;
    logic [3:0] expA;
    logic [6:0] expL, actL;
    @(negedge clk);
    for (int s = 0; s < 16; s++) begin
      slot = ((cyc - 1) / 4) % 4;
      expA = vis[slot] ? ~(4'b0001 << slot) : 4'b1111;
      expL = vis[slot] ? ~glyph[slot] : 7'h00;
      actL = vis[slot] ? led_out : 7'h00;
      compare($sformatf("%s slot%0d {anode,led,dp}", name, slot),
              {20'd0, anode_activate, actL, dp_out},
              {20'd0, expA, expL, ~dp[slot]});
      @(negedge clk);
    end
  endtask

  task automatic checkReset(input string name);
    compare({name, " anode"}, 32'(anode_activate), 32'h0000000F);
    compare({name, " led"},   32'(led_out),        32'h0000007F);
    compare({name, " dp"},    32'(dp_out),         32'h00000001);
    compare({name, " busy"},  32'(busy),           32'h00000000);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 16'hBEEF, 4'b0000, {G_B, G_E, G_E, G_F}, 4'b1111, 0};
    vecs[1]  = '{1'b1, 1'b0, 16'd1234, 4'b0000, {G_1, G_2, G_3, G_4}, 4'b1111, 16};
    vecs[2]  = '{1'b1, 1'b1, 16'd10000, 4'b0000, {G_DASH, G_DASH, G_DASH, G_DASH}, 4'b1111, 16};
    vecs[3]  = '{1'b1, 1'b1, 16'd7, 4'b0001, {G_0, G_0, G_0, G_7}, 4'b0001, 16};
    vecs[4]  = '{1'b0, 1'b1, 16'h0000, 4'b0000, {G_0, G_0, G_0, G_0}, 4'b0001, 0};
    vecs[5]  = '{1'b1, 1'b0, 16'd9999, 4'b1111, {G_9, G_9, G_9, G_9}, 4'b1111, 16};
    vecs[6]  = '{1'b1, 1'b0, 16'd65535, 4'b0000, {G_DASH, G_DASH, G_DASH, G_DASH}, 4'b1111, 16};
    vecs[7]  = '{1'b0, 1'b1, 16'h00A0, 4'b1010, {G_0, G_0, G_A, G_0}, 4'b0011, 0};
    vecs[8]  = '{1'b1, 1'b0, 16'd0, 4'b0000, {G_0, G_0, G_0, G_0}, 4'b1111, 16};
    vecs[9]  = '{1'b1, 1'b1, 16'd305, 4'b0100, {G_0, G_3, G_0, G_5}, 4'b0111, 16};
    vecs[10] = '{1'b0, 1'b0, 16'h1D2C, 4'b0000, {G_1, G_D, G_2, G_C}, 4'b1111, 0};

    repeat (3) @(negedge clk);
    checkReset("reset");
    reset = 1'b1;

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].mode, vecs[v].blank, vecs[v].num, vecs[v].dp);
      waitBusy($sformatf("vec%0d", v), vecs[v].busyLen);
      checkOutput($sformatf("vec%0d", v), vecs[v].glyph, vecs[v].vis, vecs[v].dp);
    end

    // A second load while converting is dropped and does not restart the count
    applyStimulus(1'b1, 1'b0, 16'd1234, 4'b0000);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'd9999, 4'b0000);
    waitBusy("ignored load", 13);
    checkOutput("ignored load", {G_1, G_2, G_3, G_4}, 4'b1111, 4'b0000);

    // Reset in the middle of a conversion aborts it and clears the shadow
    applyStimulus(1'b1, 1'b0, 16'd5678, 4'b0000);
    repeat (7) @(negedge clk);
    compare("busy mid-conversion", 32'(busy), 32'h00000001);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkReset("mid-conv reset");
    checkOutput("after reset", {G_0, G_0, G_0, G_0}, 4'b1111, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
Parametrised multiplexed seven-segment display driver; successor to the fixed 4-digit hex display used in the rover top level. Scans DIGITS common-anode digits with a programmable refresh rate. Supports hex or decimal (sequential binary-to-BCD) rendering, leading-zero blanking, per-digit decimal points and overflow indication. Displays sensor readings (frequency counter, proximity) on the board display.

Parameters:
DIGITS, 4, number of digits/anodes (1..8)
DATA_W, 16, width of display_number
REFRESH_DIV, 100000, clk cycles per digit slot (>=2)
ACTIVE_LOW, 1, 1 = anodes/segments/dp driven active-low

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
display_number  input  DATA_W  value to show
load  input  1  one-cycle strobe; capture display_number
mode  input  1  0 = hex, 1 = decimal; sampled on accepted load
blank_lz  input  1  1 = blank leading zeros; sampled on accepted load
dp_mask  input  DIGITS  decimal point per digit, bit0 = rightmost; live, not latched
busy  output  1  decimal conversion in progress
anode_activate  output  DIGITS  one-hot digit enable (at ACTIVE_LOW polarity)
led_out  output  7  segments, led_out[6]=a ... led_out[0]=g
dp_out  output  1  decimal point of current digit

Behaviour:
- Reset (reset==0 at clk edge): anodes all inactive, led_out all off, dp_out off, busy 0, shadow digits 0, overflow 0, scan index 0, prescaler 0. Asserting reset mid-conversion aborts it; shadow stays 0.
- FSM states: IDLE, CONV. load in IDLE accepted; load in CONV ignored (no queueing).
- Hex load (IDLE): shadow digit i = display_number[4i+3:4i] on next edge; overflow = 1 if any bit at or above 4*DIGITS set. busy stays 0.
- Decimal load: IDLE->CONV, busy=1 on next edge. Double-dabble: one shift per cycle, exactly DATA_W cycles in CONV, add-3 on BCD nibbles >=5 before each shift. Carry out of top BCD nibble sets sticky overflow. Final cycle: shadow and overflow updated together, CONV->IDLE, busy=0. Shadow never shows partial results.
- Prescaler counts 0..REFRESH_DIV-1 continuously (independent of load/busy); at terminal count, scan index increments modulo DIGITS.
- Output stage registered: anode_activate, led_out, dp_out reflect scan index one cycle after it changes.
- Digit 0 = rightmost = anode bit 0.
- Segment content: overflow -> every digit shows dash (g only), blanking suppressed. Otherwise hex glyph 0-F for shadow digit.
- Leading-zero blanking (blank_lz latched): digits above the highest non-zero digit keep anode inactive. Digit 0 never blanked; value 0 shows single "0".
- dp_out = dp_mask[scan index] even on blanked digits; anode stays inactive there, so dp is not visible.
- ACTIVE_LOW=1: inactive anode = 1, segment off = 1.

Decomposition:
- Package seg_pkg: 7-bit glyph constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK (active-high, polarity applied at output); FSM state enum; helper function for clog2 of DIGITS.
- Sub-module bin2bcd_seq: start/busy/done sequential double-dabble with overflow output, parametrised by DATA_W and DIGITS.

Test Plan (DIGITS=4, DATA_W=16, REFRESH_DIV=4, ACTIVE_LOW=1):
1. Reset held 3 cycles -> anode_activate=4'b1111, led_out=7'b1111111, dp_out=1, busy=0.
2. mode=0, load 16'hBEEF -> busy stays 0; in slot 0, anode=4'b1110, led_out=7'b0111000 (F). Full scan shows F,E,E,B on anodes 0..3.
3. mode=1, load 16'd1234 -> busy high exactly 16 cycles; then slot 0 led_out=7'b1001100 (4); digits 3,2,1 follow on anodes 1..3.
4. mode=1, load 16'd10000 -> after busy falls, all four digits led_out=7'b1111110 (dash), even with blank_lz=1.
5. mode=1, blank_lz=1, load 16'd7 -> anodes 1..3 never driven low; anode0 low once per 16-cycle frame showing 7'b0001111. dp_mask=4'b0001 -> dp_out=0 in slot 0 only.
6. Load 1234 then load 9999 during busy -> 1234 displayed, 9999 ignored. Reset at conversion cycle 8 -> busy=0, shadow 0, display shows 0000.
